// File: rtl/fifo_stream_drain.sv
// Read-side consumer of the async FIFO. It pops words whenever a buffer
// slot is guaranteed, absorbs the one-cycle read latency, and re-presents
// the words on a valid/ready stream through a two-entry head/skid buffer.
module fifo_stream_drain #(
  parameter int D_WIDTH   = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drain_en,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [D_WIDTH-1:0]   fifo_rd_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [D_WIDTH-1:0]   m_data,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic                 busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  occ_e                 r_occ;
  occ_e                 w_occNext;
  logic                 r_inflight;
  logic                 r_valid;
  logic [D_WIDTH-1:0]   r_head;
  logic [D_WIDTH-1:0]   r_skid;
  logic [D_WIDTH-1:0]   w_headNext;
  logic [D_WIDTH-1:0]   w_skidNext;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_pop;
  logic                 w_capture;
  logic [2:0]           w_level;

  // The occupancy value doubles as the word count held in the buffer, so
  // adding the in-flight bit gives the number of slots already committed.
  assign w_pop      = r_valid & m_ready;
  assign w_capture  = r_inflight;
  assign w_level    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign fifo_rd_en = reset & drain_en & ~fifo_empty & ((w_level < 3'd2) | w_pop);

  assign m_valid  = r_valid;
  assign m_data   = r_head;
  assign word_cnt = r_cnt;
  assign busy     = r_inflight | r_valid;

  // Next buffer occupancy and contents from this cycle's capture and pop.
  always_comb begin
    w_occNext  = r_occ;
    w_headNext = r_head;
    w_skidNext = r_skid;
    case (r_occ)
      EMPTY: begin
        if (w_capture) begin
          w_occNext  = ONE;
          w_headNext = fifo_rd_data;
        end
      end
      ONE: begin
        if (w_capture && w_pop) begin
          w_headNext = fifo_rd_data;
        end else if (w_capture) begin
          w_occNext  = TWO;
          w_skidNext = fifo_rd_data;
        end else if (w_pop) begin
          w_occNext = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_headNext = r_skid;
          if (w_capture) begin
            w_skidNext = fifo_rd_data;
          end else begin
            w_occNext = ONE;
          end
        end
      end
      default: begin
        w_occNext = EMPTY;
      end
    endcase
  end

  // Buffer state, read-latency tracker, registered valid and delivery count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ      <= EMPTY;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
      r_cnt      <= '0;
    end else begin
      r_occ      <= w_occNext;
      r_inflight <= fifo_rd_en;
      r_valid    <= (w_occNext != EMPTY);
      r_head     <= w_headNext;
      r_skid     <= w_skidNext;
      r_cnt      <= r_cnt + CNT_WIDTH'(w_pop);
    end
  end

  // A returning word with both slots full and nothing leaving would be lost;
  // the issue rule must make this unreachable.
  a_noOverflow : assert property (@(posedge clk) disable iff (!reset)
    !((r_occ == TWO) && r_inflight && !w_pop));

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Self-checking bench for fifo_stream_drain: a queue-based FIFO stand-in
// drives the read side and a queue-level reference model is compared
// against the stream outputs every cycle.
module tb_fifo_stream_drain;

  logic       clk = 1'b0;
  logic       reset;
  logic       drain_en;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [3:0] word_cnt;
  logic       busy;

  logic [7:0] fifoQ[$];
  logic [7:0] envWord;

  logic [7:0] mSrc[$];
  logic [7:0] mBuf[$];
  logic       mInflight;
  logic [7:0] mInWord;
  logic [3:0] mCnt;
  logic       mNextRd;

  logic [7:0] logData[$];
  int         logCyc[$];
  int         cycleNum;
  int         rdEnCount;
  int         checks;
  int         failures;

  logic       seen15;
  logic       seen16;
  logic       seen17;

  fifo_stream_drain #(
    .D_WIDTH  (8),
    .CNT_WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .drain_en    (drain_en),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .word_cnt    (word_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycleNum);
    end
  endtask

  // A read may be issued when the buffer plus the word in flight leave a
  // free slot, or when a word is leaving the buffer this cycle.
  function automatic logic computeRdEn();
    int committed;
    committed = mBuf.size() + (mInflight ? 1 : 0);
    return reset && drain_en && !fifo_empty &&
           ((committed < 2) || ((mBuf.size() > 0) && m_ready));
  endfunction

  task automatic loadWord(input logic [7:0] w);
    fifoQ.push_back(w);
    mSrc.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic holdReset();
    reset    = 1'b0;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic releaseReset();
    logData.delete();
    logCyc.delete();
    rdEnCount = 0;
    reset     = 1'b1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // FIFO stand-in: one-cycle read latency, empty flag updated at the edge.
  always @(posedge clk) begin
    if (fifo_rd_en && fifoQ.size() > 0) begin
      envWord = fifoQ.pop_front();
      fifo_rd_data <= envWord;
      fifo_empty   <= (fifoQ.size() == 0);
    end
  end

  // Reference model: queue of buffered words plus one in-flight slot.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mBuf.delete();
      mInflight = 1'b0;
      mCnt      = 4'd0;
    end else begin
      mNextRd = computeRdEn();
      if (m_valid && m_ready) begin
        logData.push_back(m_data);
        logCyc.push_back(cycleNum);
      end
      if (mBuf.size() > 0 && m_ready) begin
        void'(mBuf.pop_front());
        mCnt++;
      end
      if (mInflight) mBuf.push_back(mInWord);
      mInflight = mNextRd;
      if (mNextRd && mSrc.size() > 0) mInWord = mSrc.pop_front();
      cycleNum++;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("rdEnInReset", {31'd0, fifo_rd_en}, 32'd0);
    end else begin
      checkOutput("rdEn", {31'd0, fifo_rd_en}, {31'd0, computeRdEn()});
      checkOutput("mValid", {31'd0, m_valid}, {31'd0, mBuf.size() > 0});
      if (mBuf.size() > 0) checkOutput("mData", {24'd0, m_data}, {24'd0, mBuf[0]});
      checkOutput("busy", {31'd0, busy}, {31'd0, mInflight || (mBuf.size() > 0)});
      checkOutput("wordCnt", {28'd0, word_cnt}, {28'd0, mCnt});
      if (fifo_rd_en) rdEnCount++;
    end
  end

  initial begin
    checks       = 0;
    failures     = 0;
    cycleNum     = 0;
    rdEnCount    = 0;
    reset        = 1'b0;
    drain_en     = 1'b1;
    m_ready      = 1'b1;
    fifo_empty   = 1'b1;
    fifo_rd_data = 8'h00;
    mInflight    = 1'b0;
    mInWord      = 8'h00;
    mCnt         = 4'd0;

    // Reset holds everything idle even with words waiting, then streaming.
    holdReset();
    for (int i = 0; i < 8; i++) loadWord(8'h10 + 8'(i));
    waitCycles(3);
    checkOutput("resetRdEn", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("resetValid", {31'd0, m_valid}, 32'd0);
    checkOutput("resetCnt", {28'd0, word_cnt}, 32'd0);
    checkOutput("resetData", {24'd0, m_data}, 32'd0);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    releaseReset();
    #1;
    checkOutput("firstRdEn", {31'd0, fifo_rd_en}, 32'd1);
    @(posedge clk); #2;
    checkOutput("latencyValid1", {31'd0, m_valid}, 32'd0);
    @(posedge clk); #2;
    checkOutput("latencyValid2", {31'd0, m_valid}, 32'd1);
    checkOutput("latencyData", {24'd0, m_data}, 32'h10);
    waitCycles(12);
    checkOutput("streamRdEnCount", rdEnCount, 32'd8);
    checkOutput("streamLogSize", logData.size(), 32'd8);
    for (int i = 0; i < logData.size() && i < 8; i++) begin
      checkOutput("streamData", {24'd0, logData[i]}, 32'h10 + i);
      checkOutput("streamNoBubble", logCyc[i], logCyc[0] + i);
    end
    checkOutput("streamCnt", {28'd0, word_cnt}, 32'd8);
    checkOutput("streamBusy", {31'd0, busy}, 32'd0);

    // Back-pressure mid-burst: buffer fills, reads stop, head holds.
    holdReset();
    for (int i = 0; i < 8; i++) loadWord(8'h10 + 8'(i));
    releaseReset();
    waitCycles(4);
    m_ready = 1'b0;
    waitCycles(5);
    checkOutput("stallRdEn", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("stallValid", {31'd0, m_valid}, 32'd1);
    checkOutput("stallData", {24'd0, m_data}, 32'h12);
    checkOutput("stallLogSize", logData.size(), 32'd2);
    checkOutput("stallBusy", {31'd0, busy}, 32'd1);
    m_ready = 1'b1;
    waitCycles(15);
    checkOutput("bpLogSize", logData.size(), 32'd8);
    for (int i = 0; i < logData.size() && i < 8; i++)
      checkOutput("bpData", {24'd0, logData[i]}, 32'h10 + i);
    checkOutput("bpCnt", {28'd0, word_cnt}, 32'd8);

    // Single word: one pulse, delivered, then idle.
    holdReset();
    loadWord(8'hA5);
    releaseReset();
    waitCycles(8);
    checkOutput("emptyRdEnCount", rdEnCount, 32'd1);
    checkOutput("emptyLogSize", logData.size(), 32'd1);
    if (logData.size() > 0) checkOutput("emptyData", {24'd0, logData[0]}, 32'hA5);
    checkOutput("emptyRdEn", {31'd0, fifo_rd_en}, 32'd0);
    checkOutput("emptyBusy", {31'd0, busy}, 32'd0);
    checkOutput("emptyCnt", {28'd0, word_cnt}, 32'd1);

    // drain_en dropped right after the first issue: in-flight word survives.
    holdReset();
    for (int i = 0; i < 4; i++) loadWord(8'h30 + 8'(i));
    releaseReset();
    waitCycles(1);
    drain_en = 1'b0;
    waitCycles(6);
    checkOutput("gateRdEnCount", rdEnCount, 32'd1);
    checkOutput("gateLogSize", logData.size(), 32'd1);
    if (logData.size() > 0) checkOutput("gateData", {24'd0, logData[0]}, 32'h30);
    checkOutput("gateBusy", {31'd0, busy}, 32'd0);
    drain_en = 1'b1;
    waitCycles(10);
    checkOutput("resumeRdEnCount", rdEnCount, 32'd4);
    checkOutput("resumeLogSize", logData.size(), 32'd4);
    for (int i = 0; i < logData.size() && i < 4; i++)
      checkOutput("resumeData", {24'd0, logData[i]}, 32'h30 + i);

    // 4-bit counter wraps after 16 deliveries.
    holdReset();
    for (int i = 0; i < 17; i++) loadWord(8'h40 + 8'(i));
    releaseReset();
    seen15 = 1'b0;
    seen16 = 1'b0;
    seen17 = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (logData.size() == 15 && !seen15) begin
        seen15 = 1'b1;
        checkOutput("wrapCnt15", {28'd0, word_cnt}, 32'd15);
      end
      if (logData.size() == 16 && !seen16) begin
        seen16 = 1'b1;
        checkOutput("wrapCnt16", {28'd0, word_cnt}, 32'd0);
      end
      if (logData.size() == 17 && !seen17) begin
        seen17 = 1'b1;
        checkOutput("wrapCnt17", {28'd0, word_cnt}, 32'd1);
      end
    end
    checkOutput("wrapSeen", {29'd0, seen15, seen16, seen17}, 32'd7);
    for (int i = 0; i < logData.size() && i < 17; i++)
      checkOutput("wrapData", {24'd0, logData[i]}, 32'h40 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_drain.md
Name: fifo_stream_drain

Overview:
- Read-domain consumer of the async FIFO. Sits directly downstream of its rd_en/empty_o/rd_data interface, in the rd_clk domain.
- Pops words whenever there is room and accounts for the memory's 1-cycle read latency.
- Re-presents the words on a valid/ready stream through a 2-entry output buffer, giving full-rate, bubble-free, loss-free transfer under arbitrary back-pressure.
- Keeps a running count of delivered words.

Parameters:
- D_WIDTH, 8, data word width; must match the FIFO d_width.
- CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
- clk  input  1  read-domain clock (connects to rd_clk).
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- drain_en  input  1  permits new FIFO pops while 1; no effect on words already popped or buffered.
- fifo_empty  input  1  FIFO empty_o.
- fifo_rd_en  output  1  FIFO rd_en; combinational.
- fifo_rd_data  input  D_WIDTH  FIFO rd_data; valid the cycle after fifo_rd_en=1.
- m_valid  output  1  stream word valid; registered.
- m_ready  input  1  downstream accept.
- m_data  output  D_WIDTH  stream word; registered.
- word_cnt  output  CNT_WIDTH  words delivered (m_valid&m_ready) since reset.
- busy  output  1  1 when any word is in flight or buffered.

Behaviour:
- Reset (reset=0, async): occupancy=0, inflight=0, m_valid=0, m_data=0, word_cnt=0, busy=0; fifo_rd_en forced 0 while reset=0. Release is synchronous to the next clk edge.
- pop = m_valid & m_ready.
- Issue rule (combinational): fifo_rd_en = reset & drain_en & ~fifo_empty & ((occupancy + inflight) < 2 | pop).
  - This guarantees every issued read has a buffer slot when its data returns.
  - The pop term gives 1 word/cycle steady-state throughput.
- inflight register: next value = fifo_rd_en. At any edge where inflight=1, fifo_rd_data is captured.
- Occupancy state machine (EMPTY=0, ONE=1, TWO=2); head entry drives m_data, skid entry holds the second word:
  - EMPTY: capture -> ONE (head<=data). No capture -> stay EMPTY.
  - ONE: capture & pop -> ONE (head<=data). Capture only -> TWO (skid<=data). Pop only -> EMPTY. Neither -> stay.
  - TWO: pop & capture -> TWO (head<=skid, skid<=data). Pop only -> ONE (head<=skid). Capture in TWO without pop is impossible by the issue rule; assert it in simulation.
- m_valid = (occupancy != 0), registered. m_data holds stable while m_valid=1 and m_ready=0. m_data is unchanged when EMPTY.
- Ordering: words leave in exact FIFO pop order. No drop, no duplication.
- word_cnt: +1 on each pop; wraps from 2^CNT_WIDTH-1 to 0 silently.
- busy = inflight | (occupancy != 0).
- drain_en falling while inflight=1: the in-flight word is still captured and delivered.
- fifo_empty rising in the same cycle as a pending read: no issue that cycle. The previously issued word still lands.
- Latency: FIFO non-empty with buffer empty -> fifo_rd_en same cycle -> m_valid=1 two clk edges later.
- Reset mid-operation: buffered and in-flight words are discarded. The FIFO's own reset is the same net, so no stale return data is captured.

Test Plan:
- Reset: hold reset=0 with fifo_empty=0, drain_en=1 -> fifo_rd_en=0, m_valid=0, word_cnt=0. After release, fifo_rd_en=1 on the first cycle and m_valid=1 two edges later.
- Streaming: FIFO preloaded with 8 words 0x10..0x17, m_ready=1 constantly -> fifo_rd_en high 8 consecutive cycles. m_data=0x10..0x17 on 8 consecutive cycles, no bubbles, word_cnt=8.
- Back-pressure: same 8 words, m_ready=0 for 5 cycles mid-burst -> occupancy saturates at TWO, fifo_rd_en drops to 0, m_data holds stable. On release, data resumes in order with no loss and word_cnt=8.
- Empty boundary: FIFO holds 1 word (0xA5) -> exactly one fifo_rd_en pulse. 0xA5 delivered. fifo_rd_en stays 0 while fifo_empty=1, and busy returns to 0.
- drain_en gating: deassert drain_en the cycle after a pop is issued -> the in-flight word is delivered and no further fifo_rd_en occurs. Re-assert -> draining resumes.
- Counter wrap (CNT_WIDTH=4): deliver 17 words -> word_cnt reads 15 after 15 pops, 0 after 16, 1 after 17.
